// File: rtl/memtrace_replay_sched.sv
// Replay scheduler: pops {cycle, address} trace entries, holds each until the replay
// counter reaches its timestamp, then issues it as a memory request with bounded inflight.
module memtrace_replay_sched #(
  parameter int ADDR_W       = 64,
  parameter int CYCLE_W      = 64,
  parameter int MAX_INFLIGHT = 8,
  parameter int QUIET_CYCLES = 16,
  localparam int CNT_W       = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               trace_read_valid,
  output logic               trace_read_ready,
  input  logic [CYCLE_W-1:0] trace_read_cycle,
  input  logic [ADDR_W-1:0]  trace_read_address,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [ADDR_W-1:0]  mem_req_addr,
  input  logic               mem_resp_valid,
  output logic [CYCLE_W-1:0] now_cycle,
  output logic [CNT_W-1:0]   inflight,
  output logic [31:0]        late_count,
  output logic               busy,
  output logic               done,
  output logic               err_underflow
);

  localparam int QW = $clog2(QUIET_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CYCLE_W-1:0] now_cycle_q, now_cycle_d;
  logic [CNT_W-1:0]   inflight_q, inflight_d;
  logic [31:0]        late_count_q, late_count_d;
  logic [QW-1:0]      quiet_q, quiet_d;
  logic [CYCLE_W-1:0] entry_cycle_q, entry_cycle_d;
  logic [ADDR_W-1:0]  entry_addr_q, entry_addr_d;
  logic               err_underflow_q, err_underflow_d;
  logic               fire;
  logic               late_hit;

  // On-time issue lands one cycle after the timestamp (WAIT sees the match, ISSUE follows),
  // so only fires beyond entry_cycle+1 count as late. Extra bit avoids wrap in the sum.
  assign late_hit = {1'b0, now_cycle_q} > ({1'b0, entry_cycle_q} + (CYCLE_W + 1)'(1));

  always_comb begin
    state_d          = state_q;
    now_cycle_d      = now_cycle_q;
    inflight_d       = inflight_q;
    late_count_d     = late_count_q;
    quiet_d          = quiet_q;
    entry_cycle_d    = entry_cycle_q;
    entry_addr_d     = entry_addr_q;
    err_underflow_d  = err_underflow_q;
    trace_read_ready = 1'b0;
    mem_req_valid    = 1'b0;
    fire             = 1'b0;

    if (state_q != S_IDLE && state_q != S_DONE) begin
      now_cycle_d = now_cycle_q + CYCLE_W'(1);
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d         = S_FETCH;
          now_cycle_d     = '0;
          late_count_d    = '0;
          quiet_d         = '0;
          err_underflow_d = 1'b0;
        end
      end
      S_FETCH: begin
        trace_read_ready = 1'b1;
        if (trace_read_valid) begin
          entry_cycle_d = trace_read_cycle;
          entry_addr_d  = trace_read_address;
          quiet_d       = '0;
          state_d       = S_WAIT;
        end else begin
          quiet_d = quiet_q + QW'(1);
          if (quiet_q == QW'(QUIET_CYCLES - 1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_WAIT: begin
        if (now_cycle_q >= entry_cycle_q) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_req_valid = (inflight_q < CNT_W'(MAX_INFLIGHT));
        fire          = mem_req_valid && mem_req_ready;
        if (fire) begin
          state_d = S_FETCH;
          if (late_hit && (late_count_q != '1)) begin
            late_count_d = late_count_q + 32'd1;
          end
        end
      end
      S_DRAIN: begin
        if (inflight_q == '0) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Responses retire in every state; one arriving with nothing outstanding is flagged
    // and otherwise ignored.
    if (mem_resp_valid && (inflight_q == '0)) begin
      err_underflow_d = 1'b1;
      if (fire) begin
        inflight_d = inflight_q + CNT_W'(1);
      end
    end else if (fire && !mem_resp_valid) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (!fire && mem_resp_valid) begin
      inflight_d = inflight_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      now_cycle_q     <= '0;
      inflight_q      <= '0;
      late_count_q    <= '0;
      quiet_q         <= '0;
      entry_cycle_q   <= '0;
      entry_addr_q    <= '0;
      err_underflow_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      now_cycle_q     <= now_cycle_d;
      inflight_q      <= inflight_d;
      late_count_q    <= late_count_d;
      quiet_q         <= quiet_d;
      entry_cycle_q   <= entry_cycle_d;
      entry_addr_q    <= entry_addr_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  assign mem_req_addr  = entry_addr_q;
  assign now_cycle     = now_cycle_q;
  assign inflight      = inflight_q;
  assign late_count    = late_count_q;
  assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done          = (state_q == S_DONE);
  assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_memtrace_replay_sched.sv
// Bench for memtrace_replay_sched: directed vector table, hand-written corner sequences,
// and a randomized replay checked against a timestamp-formula reference model.
module tb_memtrace_replay_sched;

  localparam int ADDR_W  = 64;
  localparam int CYCLE_W = 64;
  localparam int MAXI    = 2;
  localparam int QUIET   = 16;
  localparam int CNT_W   = $clog2(MAXI + 1);

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic               trace_read_valid = 1'b0;
  logic               trace_read_ready;
  logic [CYCLE_W-1:0] trace_read_cycle = '0;
  logic [ADDR_W-1:0]  trace_read_address = '0;
  logic               mem_req_valid;
  logic               mem_req_ready = 1'b0;
  logic [ADDR_W-1:0]  mem_req_addr;
  logic               mem_resp_valid = 1'b0;
  logic [CYCLE_W-1:0] now_cycle;
  logic [CNT_W-1:0]   inflight;
  logic [31:0]        late_count;
  logic               busy;
  logic               done;
  logic               err_underflow;

  memtrace_replay_sched #(
    .ADDR_W(ADDR_W), .CYCLE_W(CYCLE_W), .MAX_INFLIGHT(MAXI), .QUIET_CYCLES(QUIET)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .trace_read_valid(trace_read_valid), .trace_read_ready(trace_read_ready),
    .trace_read_cycle(trace_read_cycle), .trace_read_address(trace_read_address),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .now_cycle(now_cycle), .inflight(inflight),
    .late_count(late_count), .busy(busy), .done(done), .err_underflow(err_underflow)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [63:0] src_ts[64];
  logic [63:0] src_addr[64];
  int          stall_a[64];
  logic [63:0] dut_fire_now[64];
  logic [31:0] dut_late[64];
  int          src_n = 0;
  int          src_idx = 0;
  int          fires = 0;

  typedef struct {
    logic [63:0] ts;
    logic [63:0] addr;
    int          stall;
    logic [63:0] fire_now;
    logic [31:0] late_after;
  } vec_t;

  typedef enum {M_FETCH, M_HOLD, M_DRAIN, M_DONE} mstage_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic src_drive();
    trace_read_valid = (src_idx < src_n);
    if (src_idx < src_n) begin
      trace_read_cycle   = src_ts[src_idx];
      trace_read_address = src_addr[src_idx];
    end
  endtask

  // Advance one cycle; the trace source follows its own handshake.
  task automatic step();
    bit          acc;
    bit          fr;
    logic [63:0] fa;
    logic [63:0] fn;
    acc = trace_read_valid && trace_read_ready;
    fr  = mem_req_valid && mem_req_ready;
    fa  = mem_req_addr;
    fn  = now_cycle;
    @(negedge clock);
    if (acc) src_idx++;
    if (fr) begin
      fires++;
      $display("txn fire addr=0x%0h now=%0d", fa, fn);
    end
    mem_resp_valid = 1'b0;
    src_drive();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset          = 1'b1;
    start          = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    src_n          = 0;
    src_idx        = 0;
    src_drive();
    @(negedge clock);
    reset = 1'b0;
    fires = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      step();
      n++;
    end
    chk("wait_done", 64'(done), 64'd1);
  endtask

  task automatic step_until_now(input logic [63:0] target, input int budget);
    int n;
    n = 0;
    while (now_cycle != target && n < budget) begin
      step();
      n++;
    end
    chk("reach_now", now_cycle, target);
  endtask

  // Reference model: an entry accepted at cycle a with timestamp ts becomes issuable at
  // max(a+2, ts+1); it fires on the first cycle after that with ready and spare capacity.
  // After the last entry, QUIET empty fetch cycles, then drain until nothing is outstanding.
  task automatic run_model(input int n, input bit rnd, input int budget);
    mstage_t         st;
    longint unsigned m_now;
    longint unsigned issue_at;
    longint unsigned m_late;
    longint unsigned last_due;
    longint unsigned due_q[$];
    int              m_out;
    int              cur_out;
    int              quiet;
    int              k;
    int              stall_left;
    int              dut_k;
    bit              exp_valid;
    bit              fire;
    bit              resp;
    bit              was_fire;
    bit              finished;
    st = M_FETCH; m_now = 0; issue_at = 0; m_late = 0; last_due = 0;
    m_out = 0; quiet = 0; k = 0; stall_left = 0; dut_k = 0;
    was_fire = 1'b0; finished = 1'b0;
    for (int t = 0; t < budget; t++) begin
      trace_read_valid   = (k < n);
      trace_read_cycle   = (k < n) ? src_ts[k] : 64'd0;
      trace_read_address = (k < n) ? src_addr[k] : 64'd0;
      exp_valid = (st == M_HOLD) && (m_now >= issue_at) && (m_out < MAXI);
      if (rnd) begin
        mem_req_ready = ($urandom_range(0, 3) != 0);
      end else begin
        mem_req_ready = !(exp_valid && stall_left > 0);
        if (exp_valid && stall_left > 0) stall_left--;
      end
      resp = (due_q.size() > 0) && (due_q[0] <= longint'(t));
      if (resp) void'(due_q.pop_front());
      mem_resp_valid = resp;
      fire = exp_valid && mem_req_ready;
      #1;
      if (was_fire && dut_k > 0) dut_late[dut_k-1] = late_count;
      was_fire = mem_req_valid && mem_req_ready;
      if (was_fire && dut_k < 64) begin
        dut_fire_now[dut_k] = now_cycle;
        $display("txn %0d fire addr=0x%0h now=%0d", dut_k, mem_req_addr, now_cycle);
        dut_k++;
      end
      chk("now_cycle", now_cycle, m_now);
      chk("inflight", 64'(inflight), 64'(m_out));
      chk("late_count", 64'(late_count), m_late);
      chk("req_valid", 64'(mem_req_valid), 64'(exp_valid));
      if (exp_valid) chk("req_addr", mem_req_addr, src_addr[k]);
      chk("trace_ready", 64'(trace_read_ready), 64'(st == M_FETCH));
      chk("busy", 64'(busy), 64'(st != M_DONE));
      chk("done", 64'(done), 64'(st == M_DONE));
      if (st == M_DONE) begin
        finished = 1'b1;
        break;
      end
      cur_out = m_out;
      if (resp) m_out--;
      if (fire) begin
        m_out++;
        if (m_now > src_ts[k] + 64'd1) m_late++;
        if (longint'(t) + (rnd ? longint'($urandom_range(1, 8)) : 64'd2) > last_due)
          last_due = longint'(t) + (rnd ? longint'($urandom_range(1, 8)) : 64'd2);
        due_q.push_back(last_due);
        k++;
        st = M_FETCH;
      end else begin
        case (st)
          M_FETCH: begin
            if (k < n) begin
              st         = M_HOLD;
              issue_at   = (m_now + 2 > src_ts[k] + 1) ? m_now + 2 : src_ts[k] + 1;
              quiet      = 0;
              stall_left = rnd ? 0 : stall_a[k];
            end else begin
              quiet++;
              if (quiet == QUIET) st = M_DRAIN;
            end
          end
          M_DRAIN: if (cur_out == 0) st = M_DONE;
          default: ;
        endcase
      end
      m_now++;
      @(negedge clock);
    end
    if (!finished) chk("model_budget", 64'd0, 64'd1);
    mem_resp_valid   = 1'b0;
    trace_read_valid = 1'b0;
    mem_req_ready    = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    vt[0] = '{64'd5,  64'h100, 0, 64'd6,  32'd0};
    vt[1] = '{64'd9,  64'h140, 0, 64'd10, 32'd0};
    vt[2] = '{64'd3,  64'h180, 0, 64'd13, 32'd1};
    vt[3] = '{64'd20, 64'h1C0, 3, 64'd24, 32'd2};
    vt[4] = '{64'd26, 64'h200, 0, 64'd27, 32'd2};
    vt[5] = '{64'd28, 64'h240, 1, 64'd31, 32'd3};

    // Reset state
    do_reset();
    chk("rst_now", now_cycle, 64'd0);
    chk("rst_inflight", 64'(inflight), 64'd0);
    chk("rst_late", 64'(late_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err_underflow), 64'd0);
    chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_trace_ready", 64'(trace_read_ready), 64'd0);

    // Vector table: timing, stalls and late accounting
    for (int i = 0; i < 6; i++) begin
      src_ts[i]   = vt[i].ts;
      src_addr[i] = vt[i].addr;
      stall_a[i]  = vt[i].stall;
    end
    pulse_start();
    run_model(6, 1'b0, 200);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("vec%0d_fire_now", i), dut_fire_now[i], vt[i].fire_now);
      chk($sformatf("vec%0d_late", i), 64'(dut_late[i]), 64'(vt[i].late_after));
    end
    chk("vec_final_now", now_cycle, 64'd49);
    chk("vec_final_done", 64'(done), 64'd1);
    chk("vec_final_err", 64'(err_underflow), 64'd0);

    // Inflight cap with no responses
    do_reset();
    src_n = 4;
    for (int i = 0; i < 4; i++) begin
      src_ts[i]   = 64'd0;
      src_addr[i] = 64'h1000 + 64'(i) * 64'h40;
    end
    src_drive();
    mem_req_ready = 1'b1;
    pulse_start();
    step_until_now(64'd10, 40);
    chk("cap_fires", 64'(fires), 64'd2);
    chk("cap_valid_low", 64'(mem_req_valid), 64'd0);
    chk("cap_inflight", 64'(inflight), 64'd2);
    mem_resp_valid = 1'b1;
    step();
    chk("cap_inflight_resp", 64'(inflight), 64'd1);
    chk("cap_valid_again", 64'(mem_req_valid), 64'd1);
    chk("cap_addr", mem_req_addr, 64'h1080);
    step();
    chk("cap_fires3", 64'(fires), 64'd3);
    chk("cap_inflight3", 64'(inflight), 64'd2);

    // Fire and response together, then underflow in DONE, then restart from DONE
    do_reset();
    src_n = 2;
    src_ts[0] = 64'd0; src_addr[0] = 64'h2000;
    src_ts[1] = 64'd0; src_addr[1] = 64'h2040;
    src_drive();
    mem_req_ready = 1'b1;
    pulse_start();
    step_until_now(64'd5, 20);
    chk("both_valid", 64'(mem_req_valid), 64'd1);
    chk("both_inflight_pre", 64'(inflight), 64'd1);
    mem_resp_valid = 1'b1;
    step();
    chk("both_inflight_post", 64'(inflight), 64'd1);
    chk("both_fires", 64'(fires), 64'd2);
    mem_resp_valid = 1'b1;
    step();
    chk("both_inflight_zero", 64'(inflight), 64'd0);
    wait_done(60);
    chk("both_final_now", now_cycle, 64'd23);
    chk("both_late", 64'(late_count), 64'd2);
    chk("both_err_clear", 64'(err_underflow), 64'd0);
    mem_resp_valid = 1'b1;
    step();
    chk("uf_err", 64'(err_underflow), 64'd1);
    chk("uf_inflight", 64'(inflight), 64'd0);
    chk("uf_done_held", 64'(done), 64'd1);
    pulse_start();
    chk("restart_now", now_cycle, 64'd0);
    chk("restart_err", 64'(err_underflow), 64'd0);
    chk("restart_late", 64'(late_count), 64'd0);
    chk("restart_busy", 64'(busy), 64'd1);
    chk("restart_done", 64'(done), 64'd0);
    wait_done(60);
    chk("restart_final_now", now_cycle, 64'd17);

    // Async reset while a request is pending, then start ignored while busy
    do_reset();
    src_n = 1;
    src_ts[0] = 64'd0; src_addr[0] = 64'hABC0;
    src_drive();
    mem_req_ready = 1'b0;
    pulse_start();
    step_until_now(64'd3, 20);
    chk("ar_valid_before", 64'(mem_req_valid), 64'd1);
    chk("ar_addr_before", mem_req_addr, 64'hABC0);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid_now", 64'(mem_req_valid), 64'd0);
    chk("ar_busy_now", 64'(busy), 64'd0);
    chk("ar_now_cycle", now_cycle, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    src_n = 0;
    src_idx = 0;
    src_drive();
    step(); step(); step();
    chk("ar_idle_valid", 64'(mem_req_valid), 64'd0);
    chk("ar_idle_now", now_cycle, 64'd0);
    chk("ar_idle_busy", 64'(busy), 64'd0);
    pulse_start();
    chk("ar_rerun_now0", now_cycle, 64'd0);
    step();
    chk("ar_rerun_now1", now_cycle, 64'd1);
    step(); step(); step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("busy_start_ignored", now_cycle, 64'd6);
    wait_done(60);
    chk("busy_start_final_now", now_cycle, 64'd17);

    // Randomized replay against the reference model
    do_reset();
    src_n = 40;
    for (int i = 0; i < 40; i++) begin
      src_ts[i]   = 64'(i * 5) + 64'($urandom_range(0, 12));
      src_addr[i] = {32'h0, $urandom} & ~64'h3F;
    end
    pulse_start();
    run_model(40, 1'b1, 3000);
    chk("rand_err", 64'(err_underflow), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
